// File: rtl/deser_4b5b_pkg.sv
// Shared constants, state type and 4b5b symbol decoder for the A/B channel deserialiser.
package deser_4b5b_pkg;

    localparam logic [4:0] SYM_J    = 5'b11000;
    localparam logic [4:0] SYM_K    = 5'b10001;
    localparam logic [4:0] SYM_T    = 5'b01101;
    localparam logic [4:0] SYM_IDLE = 5'b11111;
    localparam logic [9:0] J_K      = {SYM_J, SYM_K};

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    // Returns {ok, nibble}; ok=0 for control symbols and unlisted codes.
    function automatic logic [4:0] dec4b5b(input logic [4:0] sym);
        logic [4:0] res;
        res = 5'b0;
        case (sym)
            5'b11110: res = 5'h10;
            5'b01001: res = 5'h11;
            5'b10100: res = 5'h12;
            5'b10101: res = 5'h13;
            5'b01010: res = 5'h14;
            5'b01011: res = 5'h15;
            5'b01110: res = 5'h16;
            5'b01111: res = 5'h17;
            5'b10010: res = 5'h18;
            5'b10011: res = 5'h19;
            5'b10110: res = 5'h1A;
            5'b10111: res = 5'h1B;
            5'b11010: res = 5'h1C;
            5'b11011: res = 5'h1D;
            5'b11100: res = 5'h1E;
            5'b11101: res = 5'h1F;
            SYM_J, SYM_K, SYM_T, SYM_IDLE: res = 5'b0;
            default: res = 5'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/deser_4b5b_frame_nrzi.sv
// Two-bit-per-clock NRZI decoder; din[1] is the earlier line bit.
module nrzi_dec_2b (
    input  logic       clk80,
    input  logic       reset_n,
    input  logic [1:0] din,
    output logic       d1,
    output logic       d0
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = din[0];
        d1     = din[1] ^ prev_q;
        d0     = din[0] ^ din[1];
    end

    // Idle line from the demultiplexer is all ones, so the history starts at 1.
    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/deser_4b5b_frame.sv
// J-K delimited 4b5b frame deserialiser: hunts at both bit alignments, slices
// 5-bit symbols from a 2-bit/clk stream and emits nibbles with SOF/EOF/error.
module deser_4b5b_frame
    import deser_4b5b_pkg::*;
#(
    parameter int MAX_NIBBLES = 64
) (
    input  logic       clk80,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] din,
    output logic [3:0] dout,
    output logic       dout_valid,
    output logic       sof,
    output logic       eof,
    output logic       code_err,
    output logic       in_frame
);

    localparam int NW = $clog2(MAX_NIBBLES + 1);

    logic          d1;
    logic          d0;
    logic [10:0]   sr_n;
    logic [8:0]    sr_q, sr_d;
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [NW-1:0] nib_cnt_q, nib_cnt_d;
    logic          first_q, first_d;
    logic [3:0]    dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic          code_err_q, code_err_d;
    logic          sym_vld;
    logic [4:0]    sym;
    logic [4:0]    dec;
    logic          leave;

    nrzi_dec_2b u_nrzi (
        .clk80   (clk80),
        .reset_n (reset_n),
        .din     (din),
        .d1      (d1),
        .d0      (d0)
    );

    // Only nine history bits are stored; the two new bits complete the 11-bit window.
    always_comb begin
        sr_n         = {sr_q, d1, d0};
        sr_d         = sr_n[8:0];
        state_d      = state_q;
        cnt_d        = cnt_q;
        nib_cnt_d    = nib_cnt_q;
        first_d      = first_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        code_err_d   = 1'b0;
        sym_vld      = 1'b0;
        sym          = 5'b0;
        dec          = 5'b0;
        leave        = 1'b0;

        if (!enable) begin
            state_d   = HUNT;
            sr_d      = 9'b0;
            nib_cnt_d = '0;
            first_d   = 1'b1;
        end else begin
            case (state_q)
                HUNT: begin
                    if (sr_n[9:0] == J_K) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end else if (sr_n[10:1] == J_K) begin
                        state_d = DATA;
                        cnt_d   = 3'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 3'd3) begin
                        sym_vld = 1'b1;
                        sym     = sr_n[4:0];
                        cnt_d   = 3'd0;
                    end else if (cnt_q == 3'd4) begin
                        sym_vld = 1'b1;
                        sym     = sr_n[5:1];
                        cnt_d   = 3'd1;
                    end else begin
                        cnt_d = cnt_q + 3'd2;
                    end

                    // A J-K inside a frame is deliberately not re-synced: J and K decode as errors.
                    if (sym_vld) begin
                        dec = dec4b5b(sym);
                        if (dec[4]) begin
                            if (nib_cnt_q == NW'(MAX_NIBBLES)) begin
                                code_err_d = 1'b1;
                                leave      = 1'b1;
                            end else begin
                                dout_d       = dec[3:0];
                                dout_valid_d = 1'b1;
                                sof_d        = first_q;
                                first_d      = 1'b0;
                                nib_cnt_d    = nib_cnt_q + NW'(1);
                            end
                        end else if (sym == SYM_T) begin
                            eof_d = 1'b1;
                            leave = 1'b1;
                        end else begin
                            code_err_d = 1'b1;
                            leave      = 1'b1;
                        end
                    end

                    if (leave) begin
                        state_d   = HUNT;
                        nib_cnt_d = '0;
                        first_d   = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            sr_q         <= 9'b0;
            state_q      <= HUNT;
            cnt_q        <= 3'd0;
            nib_cnt_q    <= '0;
            first_q      <= 1'b1;
            dout_q       <= 4'b0;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nib_cnt_q    <= nib_cnt_d;
            first_q      <= first_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            code_err_q   <= code_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign code_err   = code_err_q;
    assign in_frame   = (state_q == DATA);

endmodule
